// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: multi-cycle load/store sequencer between the LSU stage
// and the data memory port. It splits word-crossing accesses into two beats.
// Ports:
//   clk, rst                    clock, sync active-high reset
//   req_valid/req_ready         access handshake (opcode, fun3, addr, wdata)
//   resp_valid/rdata/err        one-cycle completion pulse with load result
//   mem_req/we/addr/mask/wdata  memory beat request, held until mem_gnt
//   mem_gnt/rvalid/rdata        memory grant and read return
module lsu_mem_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        fun3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_mask,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP
    } state_t;

    state_t state, state_nxt;

    logic        is_load, is_store, legal, accept;
    logic [3:0]  sm;
    logic [7:0]  lanes;
    logic [63:0] wshift;

    logic        ld_q, split_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  mask_hi_q;
    logic [31:0] wdata_hi_q, lo_q;

    function automatic logic [31:0] load_ext(
        input logic [63:0] d,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [63:0] x;
        x = d >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{x[7]}}, x[7:0]};
            3'b100:  load_ext = {24'b0, x[7:0]};
            3'b001:  load_ext = {{16{x[15]}}, x[15:0]};
            3'b101:  load_ext = {16'b0, x[15:0]};
            default: load_ext = x[31:0];
        endcase
    endfunction

    // Request decode: legality, lane mask and lane-positioned store data.
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        legal    = 1'b0;
        if (is_load)
            legal = fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store)
            legal = fun3 inside {3'b000, 3'b001, 3'b010};
        case (fun3[1:0])
            2'b00:   sm = 4'b0001;
            2'b01:   sm = 4'b0011;
            default: sm = 4'b1111;
        endcase
        lanes  = {4'b0, sm} << addr[1:0];
        wshift = {32'b0, wdata} << {addr[1:0], 3'b000};
    end

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign mem_req    = (state == REQ1) || (state == REQ2);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal ? REQ1 : RESP;
            REQ1:    if (mem_gnt)
                         state_nxt = ld_q    ? WAIT1 :
                                     split_q ? REQ2  : RESP;
            WAIT1:   if (mem_rvalid) state_nxt = split_q ? REQ2 : RESP;
            REQ2:    if (mem_gnt) state_nxt = ld_q ? WAIT2 : RESP;
            WAIT2:   if (mem_rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q       <= 1'b0;
            split_q    <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            mask_hi_q  <= '0;
            wdata_hi_q <= '0;
            lo_q       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_mask   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                ld_q       <= is_load;
                f3_q       <= fun3;
                off_q      <= addr[1:0];
                split_q    <= |lanes[7:4];
                mask_hi_q  <= lanes[7:4];
                wdata_hi_q <= wshift[63:32];
                resp_err   <= !legal;
                resp_rdata <= '0;
                // Illegal accesses leave the beat registers untouched.
                if (legal) begin
                    mem_we    <= is_store;
                    mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    mem_mask  <= lanes[3:0];
                    mem_wdata <= wshift[31:0];
                end
            end
            // Entering the second beat: advance to the next word.
            if (state_nxt == REQ2 && state != REQ2) begin
                mem_addr  <= mem_addr + ADDR_W'(4);
                mem_mask  <= mask_hi_q;
                mem_wdata <= wdata_hi_q;
            end
            if (state == WAIT1 && mem_rvalid) begin
                lo_q <= mem_rdata;
                if (!split_q)
                    resp_rdata <= load_ext({32'b0, mem_rdata}, off_q, f3_q);
            end
            if (state == WAIT2 && mem_rvalid)
                resp_rdata <= load_ext({mem_rdata, lo_q}, off_q, f3_q);
        end
    end

endmodule
